// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Purpose  : Multicycle MIPS main control. Sequences fetch/decode/execute/
//            memory/write-back and drives every datapath strobe and select.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BEQ       = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ANDI_EXEC = 4'd11,
    ST_I_WB      = 4'd12,
    ST_ILLEGAL   = 4'd13,
    ST_UNUSED_E  = 4'd14,
    ST_UNUSED_F  = 4'd15
  } state_t;

  state_t     state_q, state_d, w_state_nxt;
  logic       is_store_q;
  logic       illegal_q, illegal_d;

  // Registered copies of the state-decoded controls; they always describe
  // state_q because they are loaded from the decode of the next state.
  logic       fetch_q,         fetch_d;
  logic       pc_write_q,      pc_write_d;
  logic       pc_write_cond_q, pc_write_cond_d;
  logic [1:0] pc_source_q,     pc_source_d;
  logic       i_or_d_q,        i_or_d_d;
  logic       mem_read_q,      mem_read_d;
  logic       mem_write_q,     mem_write_d;
  logic       reg_dst_q,       reg_dst_d;
  logic       mem_to_reg_q,    mem_to_reg_d;
  logic       reg_write_q,     reg_write_d;
  logic       alu_src_a_q,     alu_src_a_d;
  logic [1:0] alu_src_b_q,     alu_src_b_d;
  logic [3:0] alu_op_q,        alu_op_d;
  logic       w_fetch_hs;

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW: state_d = ST_MEM_ADDR;
          c_OP_RTYPE:       state_d = ST_R_EXEC;
          c_OP_BEQ:         state_d = ST_BEQ;
          c_OP_J:           state_d = ST_JUMP;
          c_OP_ADDI:        state_d = ST_ADDI_EXEC;
          c_OP_ANDI:        state_d = ST_ANDI_EXEC;
          default:          state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR:  state_d = is_store_q ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BEQ:       state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_ADDI_EXEC: state_d = ST_I_WB;
      ST_ANDI_EXEC: state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      default:      state_d = ST_ILLEGAL;  // ILLEGAL and the unused codes
    endcase
    w_state_nxt = rst_n ? state_d : ST_FETCH;
    illegal_d   = (state_d == ST_ILLEGAL) || (state_d == ST_UNUSED_E) ||
                  (state_d == ST_UNUSED_F);
  end

  // Control decode of the state the FSM is about to enter
  always_comb begin
    fetch_d         = 1'b0;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    pc_source_d     = 2'b00;
    i_or_d_d        = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 4'b0000;
    case (w_state_nxt)
      ST_FETCH:     begin fetch_d = 1'b1; mem_read_d = 1'b1; alu_src_b_d = 2'b01; end
      ST_DECODE:    alu_src_b_d = 2'b11;
      ST_MEM_ADDR:  begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; end
      ST_MEM_READ:  begin mem_read_d = 1'b1; i_or_d_d = 1'b1; end
      ST_MEM_WB:    begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; end
      ST_MEM_WRITE: begin mem_write_d = 1'b1; i_or_d_d = 1'b1; end
      ST_R_EXEC:    begin alu_src_a_d = 1'b1; alu_op_d = 4'b0010; end
      ST_R_WB:      begin reg_write_d = 1'b1; reg_dst_d = 1'b1; end
      ST_BEQ: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = 4'b0001;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      ST_JUMP:      begin pc_write_d = 1'b1; pc_source_d = 2'b10; end
      ST_ADDI_EXEC: begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; end
      ST_ANDI_EXEC: begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; alu_op_d = 4'b0011; end
      ST_I_WB:      reg_write_d = 1'b1;
      default:      ;
    endcase
  end

  // State register, sticky illegal flag and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | illegal_d;
      if (state_q == ST_DECODE) is_store_q <= (opcode == c_OP_SW);
    end
    fetch_q         <= fetch_d;
    pc_write_q      <= pc_write_d;
    pc_write_cond_q <= pc_write_cond_d;
    pc_source_q     <= pc_source_d;
    i_or_d_q        <= i_or_d_d;
    mem_read_q      <= mem_read_d;
    mem_write_q     <= mem_write_d;
    reg_dst_q       <= reg_dst_d;
    mem_to_reg_q    <= mem_to_reg_d;
    reg_write_q     <= reg_write_d;
    alu_src_a_q     <= alu_src_a_d;
    alu_src_b_q     <= alu_src_b_d;
    alu_op_q        <= alu_op_d;
  end

  // IR/PC load in FETCH follows the memory handshake; a low rst_n kills every
  // output in the same cycle so an abandoned instruction issues nothing.
  assign w_fetch_hs    = fetch_q & mem_ready;
  assign pc_write      = rst_n & (pc_write_q | w_fetch_hs);
  assign ir_write      = rst_n & w_fetch_hs;
  assign pc_write_cond = rst_n & pc_write_cond_q;
  assign mem_read      = rst_n & mem_read_q;
  assign mem_write     = rst_n & mem_write_q;
  assign reg_write     = rst_n & reg_write_q;
  assign i_or_d        = rst_n & i_or_d_q;
  assign reg_dst       = rst_n & reg_dst_q;
  assign mem_to_reg    = rst_n & mem_to_reg_q;
  assign alu_src_a     = rst_n & alu_src_a_q;
  assign pc_source     = rst_n ? pc_source_q : 2'b00;
  assign alu_src_b     = rst_n ? alu_src_b_q : 2'b00;
  assign alu_op        = rst_n ? alu_op_q    : 4'b0000;
  assign illegal_op    = rst_n & illegal_q;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the MIPS datapath. It decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and write-back steps. It drives every datapath strobe and mux select, including the 4-bit `alu_op` that the ALU control block consumes together with `funct`. Memory accesses use a `mem_ready` handshake, so the block tolerates multi-cycle memory.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `opcode`  in  6  IR[31:26]; sampled only in DECODE
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `i_or_d`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register: 0 rt, 1 rd
- `mem_to_reg`  out  1  write data: 0 ALUOut, 1 MDR
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0 PC, 1 A
- `alu_src_b`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `alu_op`  out  4  0000 add, 0001 sub, 0010 R-type (use funct), 0011 and; 0100 and above never driven
- `illegal_op`  out  1  sticky unsupported-opcode flag
- `state`  out  4  current state code (debug)

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100. Any other opcode is illegal.
- The state register is 4 bits. Outputs decode from the state, except where `mem_ready` is named below. Any output not listed for a state is 0.
- FETCH (0000): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=0000.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH until `mem_ready`=1, then go to DECODE.
- DECODE (0001): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=0000 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq → BEQ
  - j → JUMP
  - addi → ADDI_EXEC
  - andi → ANDI_EXEC
  - other → ILLEGAL
- MEM_ADDR (0010): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=0000. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ (0011): `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB (0100): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next: FETCH.
- MEM_WRITE (0101): `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`, then go to FETCH.
- R_EXEC (0110): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=0010. Next: R_WB.
- R_WB (0111): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next: FETCH.
- BEQ (1000): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=0001, `pc_write_cond`=1, `pc_source`=01. Next: FETCH.
- JUMP (1001): `pc_write`=1, `pc_source`=10. Next: FETCH.
- ADDI_EXEC (1010): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=0000. Next: I_WB.
- ANDI_EXEC (1011): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=0011. Next: I_WB.
- I_WB (1100): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next: FETCH.
- ILLEGAL (1101): all strobes 0, `illegal_op`=1. Absorbing; only reset exits.
- Unused codes 1110/1111: behave as ILLEGAL and go to ILLEGAL on the next edge.

## Timing
- Reset:
  - Rising edge with `rst_n`=0 → state FETCH (0000), `illegal_op` cleared.
  - While `rst_n`=0, `pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write` and `reg_write` are forced 0 combinationally.
  - Reset values: all outputs 0, `state`=0000.
- Reset mid-instruction (including during a `mem_ready` wait) abandons the instruction. No partial strobe is issued in the cycle `rst_n` is low.
- Cycle counts with `mem_ready` high whenever sampled:
  - lw 5; sw 4; R, addi, andi 4; beq, j 3.
  - Each extra low cycle of `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `opcode` is a don't-care outside DECODE.
- In MEM_WRITE with `mem_ready`=0, `mem_write` stays high every cycle. Memory must count one write on the `mem_ready` cycle only.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges mid-MEM_WRITE → `state`=0000, all strobes 0, `mem_write` low in the reset cycle.
- lw with `mem_ready`=1 → state sequence 0,1,2,3,4,0 over 5 cycles. `alu_op` is 0000 in cycles 1–3. Cycle 5 has `reg_write`=1, `mem_to_reg`=1.
- R-type → `alu_op`=0010 in R_EXEC; R_WB has `reg_dst`=1, `reg_write`=1. beq → BEQ has `alu_op`=0001, `pc_write_cond`=1, `pc_source`=01.
- andi then addi → ANDI_EXEC drives `alu_op`=0011, ADDI_EXEC drives 0000, both with `alu_src_b`=10. j → JUMP has `pc_write`=1, `pc_source`=10.
- `mem_ready` low for 3 cycles in FETCH, then high → `ir_write`/`pc_write` pulse exactly once, on the 4th cycle.
- Opcode 111111 → ILLEGAL, `illegal_op`=1 held for 10+ cycles with no strobes; reset clears it.
